// File: rtl/pc_unit.sv
// Program-counter unit: word-address fetch PC with stall, jump/branch redirect,
// trap vectoring, configurable reset vector and a circular return-address stack.
module pc_unit #(
  parameter int unsigned          WIDTH      = 30,
  parameter logic [WIDTH-1:0]     RESET_ADDR = '0,
  parameter int unsigned          RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             set,
  input  logic [WIDTH-1:0] jmp_addr,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] n_pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_miss
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    tp;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] nxt_pc;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;
  logic             do_miss;
  logic             do_flush;

  assign n_pc      = pc + 1'b1;
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == FULL_CNT);

  // Next-PC selection and RAS operation decode, in redirect priority order.
  // A call+ret pair on a non-empty stack collapses to an in-place overwrite
  // of the top entry (pop followed by push).
  always_comb begin
    nxt_pc   = n_pc;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_swap  = 1'b0;
    do_miss  = 1'b0;
    do_flush = 1'b0;
    if (trap) begin
      nxt_pc   = trap_vec;
      do_flush = 1'b1;
    end else if (set) begin
      nxt_pc  = jmp_addr;
      do_push = call;
    end else if (ret && !stall) begin
      if (!ras_empty) begin
        nxt_pc  = ras[tp];
        do_swap = call;
        do_pop  = !call;
      end else begin
        do_miss = 1'b1;
        do_push = call;
      end
    end else if (stall) begin
      nxt_pc = pc;
    end else begin
      do_push = call;
    end
  end

  // PC, RAS pointer/count and miss flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_ADDR;
      tp       <= '0;
      cnt      <= '0;
      ret_miss <= 1'b0;
    end else begin
      pc       <= nxt_pc;
      ret_miss <= do_miss;
      if (do_flush) begin
        cnt <= '0;
      end else if (do_push) begin
        tp <= tp + 1'b1;
        if (!ras_full) cnt <= cnt + 1'b1;
      end else if (do_pop) begin
        tp  <= tp - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end

  // RAS entry storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push) ras[tp + 1'b1] <= n_pc;
      else if (do_swap) ras[tp] <= n_pc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts the
// outputs after every edge; a monitor compares them against the DUT.
module tb_pc_unit;

  localparam int unsigned W     = 30;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] RADDR = 30'h100;

  logic clk = 1'b0;
  logic rst, stall, set, trap, call, ret;
  logic [W-1:0] jmp_addr, trap_vec;
  logic [W-1:0] pc, n_pc;
  logic ras_empty, ras_full, ret_miss;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(W), .RESET_ADDR(RADDR), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .set(set), .jmp_addr(jmp_addr),
    .trap(trap), .trap_vec(trap_vec), .call(call), .ret(ret),
    .pc(pc), .n_pc(n_pc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ret_miss(ret_miss)
  );

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] npc;
    logic         empty;
    logic         full;
    logic         miss;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_pc;
  logic [W-1:0] m_ras[$];
  int           n_cmp  = 0;
  int           n_fail = 0;

  // Reference model: the RAS is a plain bounded stack (back = top); overflow drops the oldest.
  task automatic m_push(input logic [W-1:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
  endtask

  task automatic step(input logic r, input logic tr, input logic st, input logic sl,
                      input logic c, input logic rt,
                      input logic [W-1:0] j, input logic [W-1:0] tv);
    logic [W-1:0] np;
    logic         miss;
    exp_t         e;
    rst = r; trap = tr; set = st; stall = sl; call = c; ret = rt;
    jmp_addr = j; trap_vec = tv;
    np   = m_pc + 1;
    miss = 1'b0;
    if (r) begin
      m_pc = RADDR; m_ras.delete();
    end else if (tr) begin
      m_pc = tv; m_ras.delete();
    end else if (st) begin
      m_pc = j;
      if (c) m_push(np);
    end else if (rt && !sl) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        if (c) m_push(np);
      end else begin
        miss = 1'b1;
        m_pc = np;
        if (c) m_push(np);
      end
    end else if (!sl) begin
      m_pc = np;
      if (c) m_push(np);
    end
    e.pc    = m_pc;
    e.npc   = m_pc + 1;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.miss  = miss;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("n_pc", n_pc, e.npc);
        chk("ras_empty", W'(ras_empty), W'(e.empty));
        chk("ras_full", W'(ras_full), W'(e.full));
        chk("ret_miss", W'(ret_miss), W'(e.miss));
      end
    end
  end

  // Stimulus: directed scenarios followed by biased random traffic.
  initial begin
    int guard;
    rst = 1'b1; trap = 1'b0; set = 1'b0; stall = 1'b0; call = 1'b0; ret = 1'b0;
    jmp_addr = '0; trap_vec = '0; m_pc = '0;
    @(negedge clk);
    // reset then free-run
    step(1,0,0,0,0,0,'0,'0);
    step(1,0,0,0,0,0,'0,'0);
    repeat (3) step(0,0,0,0,0,0,'0,'0);
    // stall, then set overrides stall
    step(0,0,1,0,0,0,30'h10,'0);
    step(0,0,0,1,0,0,'0,'0);
    step(0,0,0,1,0,0,'0,'0);
    step(0,0,1,1,0,0,30'h40,'0);
    // call with set, free-run, ret
    step(0,0,1,0,0,0,30'h20,'0);
    step(0,0,1,0,1,0,30'h80,'0);
    repeat (3) step(0,0,0,0,0,0,'0,'0);
    step(0,0,0,0,0,1,'0,'0);
    // five nested calls, five rets (last one misses)
    step(0,0,1,0,0,0,30'h1,'0);
    repeat (5) step(0,0,0,0,1,0,'0,'0);
    repeat (5) step(0,0,0,0,0,1,'0,'0);
    step(0,0,0,0,0,0,'0,'0);
    // trap beats set and ret, flushes RAS
    repeat (2) step(0,0,0,0,1,0,'0,'0);
    step(0,1,1,0,0,1,30'h77,30'h200);
    step(0,0,0,0,0,0,'0,'0);
    // wrap-around
    step(0,0,1,0,0,0,'1,'0);
    repeat (2) step(0,0,0,0,0,0,'0,'0);
    // combined call+ret overwrites top
    step(0,0,1,0,0,0,30'h4F,'0);
    step(0,0,0,0,1,0,'0,'0);
    step(0,0,1,0,0,0,30'h60,'0);
    step(0,0,0,0,1,1,'0,'0);
    step(0,0,0,0,0,1,'0,'0);
    // combined call+ret on empty RAS: push plus miss
    step(0,0,0,0,1,1,'0,'0);
    step(0,0,0,1,1,1,'0,'0);
    // reset wins over pending redirect/stall
    step(0,0,0,0,1,0,'0,'0);
    step(1,1,1,1,1,1,30'h3,30'h5);
    step(0,0,0,0,0,0,'0,'0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0,59) == 0), ($urandom_range(0,19) == 0),
           ($urandom_range(0,6) == 0), ($urandom_range(0,4) == 0),
           ($urandom_range(0,3) == 0), ($urandom_range(0,3) == 0),
           W'($urandom), W'($urandom));
    end
    step(0,0,0,0,0,0,'0,'0);
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
